// File: rtl/int_literal_parser.sv
// Streaming ASCII Verilog integer literal decoder: one character per handshake in,
// one decoded two's-complement value plus size/sign/base/overflow/error attributes out.
module int_literal_parser #(
   parameter int unsigned VAL_W  = 32,
   parameter int unsigned SIZE_W = 16
) (
   input  logic              CLK,
   input  logic              ASYNCRESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_char,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VAL_W-1:0]  out_value,
   output logic [SIZE_W-1:0] out_size,
   output logic              out_sized,
   output logic              out_signed,
   output logic [1:0]        out_base,
   output logic              out_overflow,
   output logic              out_error
);

   localparam int unsigned WIDE_W = VAL_W + 4;

   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_TICK  = 8'h27;
   localparam logic [7:0] CH_UNDER = 8'h5F;

   localparam logic [1:0] B_DEC = 2'd0;
   localparam logic [1:0] B_BIN = 2'd1;
   localparam logic [1:0] B_OCT = 2'd2;
   localparam logic [1:0] B_HEX = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_NUM, S_TICK, S_BASE, S_DIGITS, S_DRAIN, S_OUT
   } state_e;

   state_e             state_q, state_d;
   logic [VAL_W-1:0]   acc_q, acc_d;
   logic [SIZE_W-1:0]  size_q, size_d;
   logic               sized_q, sized_d;
   logic               sgn_q, sgn_d;
   logic               neg_q, neg_d;
   logic [1:0]         base_q, base_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;
   logic               seen_q, seen_d;
   logic               us_q, us_d;

   logic [4:0]         dig_c;
   logic [4:0]         radix_c;
   logic [WIDE_W-1:0]  mac_c;
   logic               mac_ovf_c;
   logic [7:0]         lower_c;
   logic               go_err_c;

   // {valid, value} of a character as a digit of the given base
   function automatic logic [4:0] dig_decode(input logic [7:0] ch, input logic [1:0] base);
      logic [4:0] r;
      r = '0;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         r[3:0] = 4'(ch - 8'h30);
         case (base)
            B_BIN:   r[4] = (r[3:0] < 4'd2);
            B_OCT:   r[4] = (r[3:0] < 4'd8);
            default: r[4] = 1'b1;
         endcase
      end else if (base == B_HEX && ch >= 8'h61 && ch <= 8'h66) begin
         r = {1'b1, 4'(ch - 8'h57)};
      end else if (base == B_HEX && ch >= 8'h41 && ch <= 8'h46) begin
         r = {1'b1, 4'(ch - 8'h37)};
      end
      return r;
   endfunction

   always_comb begin
      case (base_q)
         B_BIN:   radix_c = 5'd2;
         B_OCT:   radix_c = 5'd8;
         B_HEX:   radix_c = 5'd16;
         default: radix_c = 5'd10;
      endcase
   end

   // base_q stays decimal until the base letter, so one decoder serves size and digits
   assign dig_c     = dig_decode(in_char, base_q);
   assign mac_c     = WIDE_W'(acc_q) * WIDE_W'(radix_c) + WIDE_W'(dig_c[3:0]);
   assign mac_ovf_c = |mac_c[WIDE_W-1:VAL_W];
   assign lower_c   = in_char | 8'h20;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      size_d   = size_q;
      sized_d  = sized_q;
      sgn_d    = sgn_q;
      neg_d    = neg_q;
      base_d   = base_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      seen_d   = seen_q;
      us_d     = us_q;
      go_err_c = 1'b0;

      if (state_q == S_OUT) begin
         if (out_ready) begin
            state_d = S_IDLE;
            acc_d   = '0;
            size_d  = '0;
            sized_d = 1'b0;
            sgn_d   = 1'b0;
            neg_d   = 1'b0;
            base_d  = B_DEC;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            seen_d  = 1'b0;
            us_d    = 1'b0;
         end
      end else if (in_valid) begin
         case (state_q)
            S_IDLE: begin
               if (in_char == CH_MINUS) begin
                  neg_d   = 1'b1;
                  state_d = S_NUM;
               end else if (dig_c[4]) begin
                  acc_d   = mac_c[VAL_W-1:0];
                  seen_d  = 1'b1;
                  state_d = S_NUM;
               end else if (in_char == CH_TICK) begin
                  state_d = S_TICK;
               end else begin
                  go_err_c = 1'b1;
               end
            end
            S_NUM: begin
               if (dig_c[4]) begin
                  acc_d  = mac_c[VAL_W-1:0];
                  ovf_d  = ovf_q | mac_ovf_c;
                  seen_d = 1'b1;
                  us_d   = 1'b0;
               end else if (in_char == CH_UNDER && seen_q) begin
                  us_d = 1'b1;
               end else if (in_char == CH_TICK) begin
                  // the size must end on a digit and fit the size register
                  if (neg_q || !seen_q || us_q || ovf_q || acc_q == '0 ||
                      (acc_q >> SIZE_W) != '0) begin
                     go_err_c = 1'b1;
                  end else begin
                     size_d  = SIZE_W'(acc_q);
                     acc_d   = '0;
                     sized_d = 1'b1;
                     state_d = S_TICK;
                  end
               end else begin
                  go_err_c = 1'b1;
               end
            end
            S_TICK: begin
               if (lower_c == 8'h73 && !sgn_q) begin
                  sgn_d = 1'b1;
               end else if (lower_c == 8'h64) begin
                  base_d  = B_DEC;
                  state_d = S_BASE;
               end else if (lower_c == 8'h62) begin
                  base_d  = B_BIN;
                  state_d = S_BASE;
               end else if (lower_c == 8'h6F) begin
                  base_d  = B_OCT;
                  state_d = S_BASE;
               end else if (lower_c == 8'h68) begin
                  base_d  = B_HEX;
                  state_d = S_BASE;
               end else begin
                  go_err_c = 1'b1;
               end
            end
            S_BASE, S_DIGITS: begin
               if (dig_c[4]) begin
                  acc_d   = mac_c[VAL_W-1:0];
                  ovf_d   = ovf_q | mac_ovf_c;
                  state_d = S_DIGITS;
               end else if (!(in_char == CH_UNDER && state_q == S_DIGITS)) begin
                  go_err_c = 1'b1;
               end
            end
            default: ;
         endcase

         if (go_err_c) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
         end

         // a literal ending before any value digit is malformed
         if (in_last) begin
            if (state_d == S_IDLE || state_d == S_TICK || state_d == S_BASE ||
                (state_d == S_NUM && !seen_d)) begin
               err_d = 1'b1;
            end
            state_d = S_OUT;
         end
      end
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         size_q  <= '0;
         sized_q <= 1'b0;
         sgn_q   <= 1'b0;
         neg_q   <= 1'b0;
         base_q  <= B_DEC;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         seen_q  <= 1'b0;
         us_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         size_q  <= size_d;
         sized_q <= sized_d;
         sgn_q   <= sgn_d;
         neg_q   <= neg_d;
         base_q  <= base_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         seen_q  <= seen_d;
         us_q    <= us_d;
      end
   end

   logic [VAL_W-1:0] mask_c;
   logic [VAL_W-1:0] shifted_c;
   logic             small_c;
   logic             trunc_ovf_c;
   logic [VAL_W-1:0] fin_c;

   // finalize purely from registers so the result holds while out_ready is low
   always_comb begin
      small_c     = sized_q && (32'(size_q) < 32'(VAL_W));
      mask_c      = ~({VAL_W{1'b1}} << size_q);
      shifted_c   = acc_q >> (size_q - SIZE_W'(1));
      trunc_ovf_c = 1'b0;
      fin_c       = acc_q;
      if (!sized_q) begin
         if (neg_q) fin_c = VAL_W'(0) - acc_q;
      end else if (small_c) begin
         trunc_ovf_c = |(acc_q & ~mask_c);
         fin_c       = acc_q & mask_c;
         if (sgn_q && shifted_c[0]) fin_c = fin_c | ~mask_c;
      end
   end

   assign in_ready     = (state_q != S_OUT);
   assign out_valid    = (state_q == S_OUT);
   assign out_value    = err_q ? '0 : fin_c;
   assign out_size     = size_q;
   assign out_sized    = sized_q;
   assign out_signed   = sgn_q | neg_q;
   assign out_base     = base_q;
   assign out_overflow = ovf_q | trunc_ovf_c;
   assign out_error    = err_q;

endmodule

// File: tb/tb_int_literal_parser.sv
// Directed bench for int_literal_parser: literals in, expected decoded fields checked
// with immediate assertions, including stall, error recovery and async reset.
module tb_int_literal_parser;

   logic        CLK = 1'b0;
   logic        ASYNCRESET;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_char;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_value;
   logic [15:0] out_size;
   logic        out_sized;
   logic        out_signed;
   logic [1:0]  out_base;
   logic        out_overflow;
   logic        out_error;

   int n_cmp = 0;
   int n_err = 0;

   int_literal_parser #(.VAL_W(32), .SIZE_W(16)) dut (
      .CLK          (CLK),
      .ASYNCRESET   (ASYNCRESET),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_char      (in_char),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_value    (out_value),
      .out_size     (out_size),
      .out_sized    (out_sized),
      .out_signed   (out_signed),
      .out_base     (out_base),
      .out_overflow (out_overflow),
      .out_error    (out_error)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; each character is accepted on the following posedge
   task automatic send_str(input string s, input bit end_lit);
      for (int i = 0; i < s.len(); i++) begin
         in_valid = 1'b1;
         in_char  = s[i];
         in_last  = end_lit && (i == s.len() - 1);
         chk({s, " in_ready"}, in_ready, 1);
         @(negedge CLK);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_lit(input string tag, input logic [31:0] v, input logic [15:0] sz,
                             input logic szd, input logic sgn, input logic [1:0] b,
                             input logic ov, input logic er);
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " value"}, out_value, v);
      chk({tag, " size"}, out_size, sz);
      chk({tag, " sized"}, out_sized, szd);
      chk({tag, " signed"}, out_signed, sgn);
      chk({tag, " base"}, out_base, b);
      chk({tag, " overflow"}, out_overflow, ov);
      chk({tag, " error"}, out_error, er);
      chk({tag, " in_ready busy"}, in_ready, 0);
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      chk({tag, " released valid"}, out_valid, 0);
      chk({tag, " released ready"}, in_ready, 1);
   endtask

   task automatic lit(input string s, input logic [31:0] v, input logic [15:0] sz,
                      input logic szd, input logic sgn, input logic [1:0] b,
                      input logic ov, input logic er);
      send_str(s, 1'b1);
      expect_lit(s, v, sz, szd, sgn, b, ov, er);
   endtask

   initial begin
      ASYNCRESET = 1'b1;
      in_valid   = 1'b0;
      in_char    = 8'h00;
      in_last    = 1'b0;
      out_ready  = 1'b0;
      repeat (2) @(negedge CLK);
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset value", out_value, 0);
      chk("reset fields", {out_size, out_sized, out_signed, out_base, out_overflow, out_error}, 0);
      ASYNCRESET = 1'b0;
      @(negedge CLK);

      lit("32'hDEADBEEF", 32'hDEADBEEF, 16'd32, 1, 0, 2'b11, 0, 0);
      lit("'hEF",         32'd239,      16'd0,  0, 0, 2'b11, 0, 0);
      lit("24'sd23",      32'd23,       16'd24, 1, 1, 2'b00, 0, 0);
      lit("16'b10111",    32'd23,       16'd16, 1, 0, 2'b01, 0, 0);
      lit("13'o742",      32'd482,      16'd13, 1, 0, 2'b10, 0, 0);
      lit("17",           32'd17,       16'd0,  0, 0, 2'b00, 0, 0);
      lit("-559038737",   32'hDEADBEEF, 16'd0,  0, 1, 2'b00, 0, 0);
      lit("4'sb1010",     32'hFFFFFFFA, 16'd4,  1, 1, 2'b01, 0, 0);
      lit("4'hFF",        32'h0000000F, 16'd4,  1, 0, 2'b11, 1, 0);

      lit("8'hG1",        32'd0, 16'd8, 1, 0, 2'b11, 0, 1);
      lit("8'h",          32'd0, 16'd8, 1, 0, 2'b11, 0, 1);
      lit("1_'d0",        32'd0, 16'd0, 0, 0, 2'b00, 0, 1);
      lit("-8'd5",        32'd0, 16'd0, 0, 1, 2'b00, 0, 1);
      lit("5",            32'd5, 16'd0, 0, 0, 2'b00, 0, 0);

      // consumer stall: a pending character must not be taken while the result waits
      send_str("17", 1'b1);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_char  = 8'h39;
         in_last  = 1'b1;
         @(negedge CLK);
         chk("stall out_valid", out_valid, 1);
         chk("stall in_ready", in_ready, 0);
         chk("stall value", out_value, 17);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_lit("17 after stall", 32'd17, 16'd0, 0, 0, 2'b00, 0, 0);
      lit("42", 32'd42, 16'd0, 0, 0, 2'b00, 0, 0);

      // async reset between clock edges drops the partial literal at once
      send_str("32'hDE", 1'b0);
      #3 ASYNCRESET = 1'b1;
      #1;
      chk("async rst out_valid", out_valid, 0);
      chk("async rst in_ready", in_ready, 1);
      chk("async rst value", out_value, 0);
      chk("async rst sized", out_sized, 0);
      #2 ASYNCRESET = 1'b0;
      @(negedge CLK);
      lit("12", 32'd12, 16'd0, 0, 0, 2'b00, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
